imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the combinational immediate generator.
- Accepts raw 32-bit instructions over a valid/ready handshake.
- Derives the opcode internally, classifies the format (I/S/B/U/J/none), and sign-extends the immediate to XLEN.
- Presents immediate, format and illegal flag one cycle later through a 2-entry skid buffer.
- Sits between fetch and decode/execute; supports RV32 and RV64 data paths and pipeline flush.

Parameters:
XLEN, 32, width of the produced immediate; legal values 32 or 64
PASS_INST, 1, when 1 the accepted instruction is carried alongside the immediate on o_inst; when 0 o_inst is tied to 0

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous reset, active-high
i_flush  input  1  synchronous flush; discards all buffered entries
i_valid  input  1  upstream instruction valid
o_ready  output  1  block can accept an instruction this cycle
i_inst  input  32  raw instruction (`INST_WIDTH)
o_valid  output  1  output entry valid
i_ready  input  1  downstream accepts the output entry
o_imm  output  XLEN  sign-extended immediate
o_fmt  output  3  immediate format code (package constants)
o_illegal  output  1  opcode not recognised
o_inst  output  32  instruction that produced o_imm

Behaviour:
- Reset (i_rst=1 at a clock edge): state EMPTY. o_valid=0, o_ready=1, o_imm=0, o_fmt=FMT_NONE, o_illegal=0, o_inst=0.
- Handshakes:
  - Input is accepted when i_valid & o_ready.
  - Output is consumed when o_valid & i_ready.
  - Payload outputs hold stable while o_valid & !i_ready.
- Latency and throughput: accepted instruction appears on the outputs the next cycle; sustained throughput is 1 per cycle.
- o_ready is registered: o_ready = (state != FULL).
- States and transitions (main register M, skid register S):
  - EMPTY: accept -> BUSY, M <= new.
  - BUSY:
    - accept & consume -> BUSY, M <= new.
    - accept & !consume -> FULL, S <= new.
    - !accept & consume -> EMPTY.
    - else stay BUSY.
  - FULL: consume -> BUSY, M <= S; no accept is possible.
- Ordering: strictly in order; no entry is dropped or duplicated.
- Flush:
  - i_flush=1 forces state EMPTY next cycle and drops any instruction presented that cycle (flush wins over accept).
  - o_valid=0 the following cycle.
- Reset has priority over flush.
- Immediate formats (opcode = i_inst[6:0], sign bit = i_inst[31] replicated to XLEN):
  - I (OP_ALUI, OP_LOAD, OP_JALR, FENCE): inst[31:20]
  - S (OP_STORE): {inst[31:25], inst[11:7]}
  - B (OP_BRANCH): {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U (OP_LUI, OP_AUIPC): {inst[31:12], 12'h0}; for XLEN=64, bits 63:32 are copies of inst[31]
  - J (OP_JAL): {inst[31], inst[19:12], inst[20], inst[30:21], 0}; full XLEN sign extension
  - R-type (OP_ALU): o_imm=0, FMT_NONE, legal
  - SYSTEM: o_imm=0, FMT_NONE, legal (unless the optional feature is enabled)
  - Any other opcode: o_imm=0, FMT_NONE, o_illegal=1
- o_illegal is informational; the entry still flows through the handshake normally.

Optional Feature:
IMMGEN_ZICSR_EN
- Defined: for the SYSTEM opcode, o_fmt=FMT_CSR.
  - funct3[2]=1: o_imm = zero-extended zimm inst[19:15].
  - funct3 in {001, 010, 011}: o_imm = zero-extended CSR address inst[31:20].
  - funct3=000: o_imm=0.
- Undefined: SYSTEM opcode gives o_imm=0, FMT_NONE, legal; FMT_CSR is never produced.

Decomposition:
- Shared definitions.vh:
  - existing OP_* opcode constants and INST_WIDTH
  - new FMT_NONE/I/S/B/U/J/CSR 3-bit codes
  - OP_FENCE and OP_SYSTEM constants
- Sub-module imm_format_decode: purely combinational; i_inst -> {imm[XLEN-1:0], fmt, illegal}, parametrised by XLEN.
- imm_gen_pipe holds the skid-buffer FSM and registers only.

Test Plan:
- XLEN=32, single issue 0xFFF00093 (addi x1,x0,-1), i_ready=1 -> next cycle o_valid=1, o_imm=0xFFFFFFFF, fmt=FMT_I, illegal=0.
- 0xFFDFF06F (jal x0,-4) -> o_imm=0xFFFFFFFC, FMT_J; 0xFE000CE3 (beq -8) -> o_imm=0xFFFFFFF8, FMT_B.
- XLEN=64, 0x800000B7 (lui x1,0x80000) -> o_imm=0xFFFFFFFF80000000, FMT_U; 0x0000007F -> o_imm=0, illegal=1.
- Back-to-back issue of A, B, C with i_ready=0 for 3 cycles -> o_ready drops after B is captured; C is held upstream; after i_ready=1, outputs appear in order A, B, C, one per cycle.
- State FULL plus i_flush=1 with i_valid=1 -> next cycle o_valid=0, o_ready=1; the flushed-cycle input never appears at the output.
- With IMMGEN_ZICSR_EN, 0x3002D073 (csrrwi x0,mstatus,5) -> o_imm=5, FMT_CSR. Without the macro -> o_imm=0, FMT_NONE, illegal=0.

Source files
------------

// File: rtl/imm_gen_pipe_pkg.sv
// Shared opcode, format and width constants for the pipelined immediate generator.
// Defining IMMGEN_ZICSR_EN makes SYSTEM instructions produce FMT_CSR immediates.
package imm_gen_pipe_pkg;

    localparam int INST_WIDTH = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_CSR  = 3'd6;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational opcode classification and XLEN sign-extended immediate extraction.
// IMMGEN_ZICSR_EN selects CSR address / zimm extraction for the SYSTEM opcode.
module imm_format_decode
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [INST_WIDTH-1:0] i_inst,
    output logic [XLEN-1:0]       o_imm,
    output logic [2:0]            o_fmt,
    output logic                  o_illegal
);

    logic [6:0] opcode;

    assign opcode = i_inst[6:0];

    // Each immediate is assembled as a signed field, so the size cast sign-extends to XLEN.
    always_comb begin
        o_imm     = '0;
        o_fmt     = FMT_NONE;
        o_illegal = 1'b0;
        case (opcode)
            OP_ALUI, OP_LOAD, OP_JALR, OP_FENCE: begin
                o_imm = XLEN'($signed(i_inst[31:20]));
                o_fmt = FMT_I;
            end
            OP_STORE: begin
                o_imm = XLEN'($signed({i_inst[31:25], i_inst[11:7]}));
                o_fmt = FMT_S;
            end
            OP_BRANCH: begin
                o_imm = XLEN'($signed({i_inst[31], i_inst[7], i_inst[30:25],
                                       i_inst[11:8], 1'b0}));
                o_fmt = FMT_B;
            end
            OP_LUI, OP_AUIPC: begin
                o_imm = XLEN'($signed({i_inst[31:12], 12'h000}));
                o_fmt = FMT_U;
            end
            OP_JAL: begin
                o_imm = XLEN'($signed({i_inst[31], i_inst[19:12], i_inst[20],
                                       i_inst[30:21], 1'b0}));
                o_fmt = FMT_J;
            end
            OP_ALU: begin
                o_fmt = FMT_NONE;
            end
            OP_SYSTEM: begin
`ifdef IMMGEN_ZICSR_EN
                o_fmt = FMT_CSR;
                if (i_inst[14]) begin
                    o_imm = XLEN'(i_inst[19:15]);
                end else if (i_inst[13:12] != 2'b00) begin
                    o_imm = XLEN'(i_inst[31:20]);
                end
`else
                o_fmt = FMT_NONE;
`endif
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode feeds a 2-entry skid buffer, 1-cycle latency.
// o_ready is registered and drops only when both entries are held; IMMGEN_ZICSR_EN enables CSR immediates.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int PASS_INST = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [INST_WIDTH-1:0] i_inst,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [XLEN-1:0]       o_imm,
    output logic [2:0]            o_fmt,
    output logic                  o_illegal,
    output logic [INST_WIDTH-1:0] o_inst
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [XLEN-1:0]       dec_imm;
    logic [2:0]            dec_fmt;
    logic                  dec_ill;
    logic [INST_WIDTH-1:0] new_inst;

    logic [1:0]            state_q, state_d;
    logic                  ready_q, valid_q;

    logic [XLEN-1:0]       m_imm_q, m_imm_d, s_imm_q, s_imm_d;
    logic [2:0]            m_fmt_q, m_fmt_d, s_fmt_q, s_fmt_d;
    logic                  m_ill_q, m_ill_d, s_ill_q, s_ill_d;
    logic [INST_WIDTH-1:0] m_inst_q, m_inst_d, s_inst_q, s_inst_d;

    logic                  accept, consume;

    imm_format_decode #(
        .XLEN      (XLEN)
    ) u_decode (
        .i_inst    (i_inst),
        .o_imm     (dec_imm),
        .o_fmt     (dec_fmt),
        .o_illegal (dec_ill)
    );

    generate
        if (PASS_INST != 0) begin : g_pass_inst
            assign new_inst = i_inst;
        end else begin : g_no_inst
            assign new_inst = '0;
        end
    endgenerate

    // Flush beats accept: a flushed cycle never captures the presented instruction.
    assign accept  = i_valid & ready_q & ~i_flush;
    assign consume = valid_q & i_ready;

    always_comb begin
        state_d  = state_q;
        m_imm_d  = m_imm_q;
        m_fmt_d  = m_fmt_q;
        m_ill_d  = m_ill_q;
        m_inst_d = m_inst_q;
        s_imm_d  = s_imm_q;
        s_fmt_d  = s_fmt_q;
        s_ill_d  = s_ill_q;
        s_inst_d = s_inst_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d  = ST_BUSY;
                    m_imm_d  = dec_imm;
                    m_fmt_d  = dec_fmt;
                    m_ill_d  = dec_ill;
                    m_inst_d = new_inst;
                end
            end
            ST_BUSY: begin
                if (accept && consume) begin
                    m_imm_d  = dec_imm;
                    m_fmt_d  = dec_fmt;
                    m_ill_d  = dec_ill;
                    m_inst_d = new_inst;
                end else if (accept) begin
                    state_d  = ST_FULL;
                    s_imm_d  = dec_imm;
                    s_fmt_d  = dec_fmt;
                    s_ill_d  = dec_ill;
                    s_inst_d = new_inst;
                end else if (consume) begin
                    state_d  = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (consume) begin
                    state_d  = ST_BUSY;
                    m_imm_d  = s_imm_q;
                    m_fmt_d  = s_fmt_q;
                    m_ill_d  = s_ill_q;
                    m_inst_d = s_inst_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        if (i_flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_EMPTY;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            m_imm_q  <= '0;
            m_fmt_q  <= FMT_NONE;
            m_ill_q  <= 1'b0;
            m_inst_q <= '0;
            s_imm_q  <= '0;
            s_fmt_q  <= FMT_NONE;
            s_ill_q  <= 1'b0;
            s_inst_q <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= (state_d != ST_FULL);
            valid_q  <= (state_d != ST_EMPTY);
            m_imm_q  <= m_imm_d;
            m_fmt_q  <= m_fmt_d;
            m_ill_q  <= m_ill_d;
            m_inst_q <= m_inst_d;
            s_imm_q  <= s_imm_d;
            s_fmt_q  <= s_fmt_d;
            s_ill_q  <= s_ill_d;
            s_inst_q <= s_inst_d;
        end
    end

    assign o_ready   = ready_q;
    assign o_valid   = valid_q;
    assign o_imm     = m_imm_q;
    assign o_fmt     = m_fmt_q;
    assign o_illegal = m_ill_q;
    assign o_inst    = m_inst_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Drives an RV32 (instruction passed through) and an RV64 (no pass-through) instance in lockstep
// and compares both against a queue-based reference of the skid buffer and immediate rules.
module tb_imm_gen_pipe;
    import imm_gen_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_vld, out_rdy;
    logic [31:0] inst;

    logic        rdy32, vld32, ill32;
    logic [31:0] imm32, oinst32;
    logic [2:0]  fmt32;
    logic        rdy64, vld64, ill64;
    logic [63:0] imm64;
    logic [31:0] oinst64;
    logic [2:0]  fmt64;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] inst;
    } ent_t;

    ent_t       q[$];
    logic [6:0] ops [0:11];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .PASS_INST(1)) dut32 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(in_vld), .o_ready(rdy32),
        .i_inst(inst), .o_valid(vld32), .i_ready(out_rdy), .o_imm(imm32), .o_fmt(fmt32),
        .o_illegal(ill32), .o_inst(oinst32)
    );

    imm_gen_pipe #(.XLEN(64), .PASS_INST(0)) dut64 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(in_vld), .o_ready(rdy64),
        .i_inst(inst), .o_valid(vld64), .i_ready(out_rdy), .o_imm(imm64), .o_fmt(fmt64),
        .o_illegal(ill64), .o_inst(oinst64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Immediates computed as signed integers from the instruction fields.
    function automatic ent_t ref_model(input logic [31:0] in);
        ent_t   e;
        longint v;
        v      = 0;
        e.fmt  = FMT_NONE;
        e.ill  = 1'b0;
        e.inst = in;
        case (in[6:0])
            OP_LOAD, OP_ALUI, OP_JALR, OP_FENCE: begin
                v = longint'(in[31:20]);
                if (v >= 2048) v = v - 4096;
                e.fmt = FMT_I;
            end
            OP_STORE: begin
                v = longint'({in[31:25], in[11:7]});
                if (v >= 2048) v = v - 4096;
                e.fmt = FMT_S;
            end
            OP_BRANCH: begin
                v = longint'({in[31], in[7], in[30:25], in[11:8]}) * 2;
                if (v >= 4096) v = v - 8192;
                e.fmt = FMT_B;
            end
            OP_LUI, OP_AUIPC: begin
                v = longint'(in[31:12]) * 4096;
                if (v >= 64'sd2147483648) v = v - 64'sd4294967296;
                e.fmt = FMT_U;
            end
            OP_JAL: begin
                v = longint'({in[31], in[19:12], in[20], in[30:21]}) * 2;
                if (v >= 1048576) v = v - 2097152;
                e.fmt = FMT_J;
            end
            OP_ALU: begin
                v = 0;
            end
            OP_SYSTEM: begin
`ifdef IMMGEN_ZICSR_EN
                e.fmt = FMT_CSR;
                if (in[14]) v = longint'(in[19:15]);
                else if (in[13:12] != 2'b00) v = longint'(in[31:20]);
`else
                v = 0;
`endif
            end
            default: begin
                e.ill = 1'b1;
            end
        endcase
        e.imm = v;
        return e;
    endfunction

    task automatic check_outputs();
        check("ready32", 64'(rdy32), 64'(q.size() < 2));
        check("ready64", 64'(rdy64), 64'(q.size() < 2));
        check("valid32", 64'(vld32), 64'(q.size() > 0));
        check("valid64", 64'(vld64), 64'(q.size() > 0));
        if (q.size() > 0) begin
            check("imm32",  64'(imm32),   64'(q[0].imm[31:0]));
            check("fmt32",  64'(fmt32),   64'(q[0].fmt));
            check("ill32",  64'(ill32),   64'(q[0].ill));
            check("inst32", 64'(oinst32), 64'(q[0].inst));
            check("imm64",  imm64,        q[0].imm);
            check("fmt64",  64'(fmt64),   64'(q[0].fmt));
            check("ill64",  64'(ill64),   64'(q[0].ill));
            check("inst64", 64'(oinst64), 64'd0);
        end
    endtask

    task automatic step();
        bit acc, con;
        @(posedge clk);
        acc = in_vld && (q.size() < 2);
        con = (q.size() > 0) && out_rdy;
        if (rst || flush) begin
            q.delete();
        end else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back(ref_model(inst));
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic issue_one(input logic [31:0] ins);
        inst    = ins;
        in_vld  = 1'b1;
        out_rdy = 1'b1;
        step();
        in_vld  = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] e32, input logic [63:0] e64,
                              input logic [2:0] efmt, input logic eill);
        check({tag, "_imm32"}, 64'(imm32), 64'(e32));
        check({tag, "_imm64"}, imm64, e64);
        check({tag, "_fmt"},   64'(fmt32), 64'(efmt));
        check({tag, "_ill"},   64'(ill64), 64'(eill));
    endtask

    initial begin
        ops[0] = OP_LOAD;   ops[1] = OP_FENCE;  ops[2]  = OP_ALUI;   ops[3]  = OP_AUIPC;
        ops[4] = OP_STORE;  ops[5] = OP_ALU;    ops[6]  = OP_LUI;    ops[7]  = OP_BRANCH;
        ops[8] = OP_JALR;   ops[9] = OP_JAL;    ops[10] = OP_SYSTEM; ops[11] = 7'h7F;

        rst = 1'b1; flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; inst = 32'h0;
        step();
        step();
        rst = 1'b0;
        check("rst_imm32", 64'(imm32), 64'd0);
        check("rst_imm64", imm64, 64'd0);
        check("rst_fmt",   64'(fmt32), 64'(FMT_NONE));
        check("rst_ill",   64'(ill32), 64'd0);
        check("rst_inst",  64'(oinst32), 64'd0);

        issue_one(32'hFFF00093); expect_out("addi", 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, FMT_I, 1'b0);
        issue_one(32'hFFDFF06F); expect_out("jal",  32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, FMT_J, 1'b0);
        issue_one(32'hFE000CE3); expect_out("beq",  32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, FMT_B, 1'b0);
        issue_one(32'hFE112E23); expect_out("sw",   32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, FMT_S, 1'b0);
        issue_one(32'h800000B7); expect_out("lui",  32'h80000000, 64'hFFFFFFFF80000000, FMT_U, 1'b0);
        issue_one(32'h0000007F); expect_out("bad",  32'h0,        64'h0,                FMT_NONE, 1'b1);
`ifdef IMMGEN_ZICSR_EN
        issue_one(32'h3002D073); expect_out("csrwi", 32'h5, 64'h5, FMT_CSR, 1'b0);
`else
        issue_one(32'h3002D073); expect_out("csrwi", 32'h0, 64'h0, FMT_NONE, 1'b0);
`endif
        step();

        // A, B, C back to back while downstream stalls for three cycles.
        out_rdy = 1'b0; in_vld = 1'b1;
        inst = 32'h00100093; step();
        inst = 32'h00200093; step();
        check("b2b_ready_full", 64'(rdy32), 64'd0);
        inst = 32'h00300093; step();
        check("b2b_hold_a", 64'(oinst32), 64'h00100093);
        out_rdy = 1'b1; step();
        check("b2b_out_b", 64'(oinst32), 64'h00200093);
        step();
        in_vld = 1'b0;
        check("b2b_out_c", 64'(oinst32), 64'h00300093);
        step();

        // Fill both entries, then flush while a new instruction is offered.
        out_rdy = 1'b0; in_vld = 1'b1;
        inst = 32'h00400093; step();
        inst = 32'h00500093; step();
        flush = 1'b1; inst = 32'h00600093; step();
        flush = 1'b0; in_vld = 1'b0;
        check("flush_valid", 64'(vld32), 64'd0);
        check("flush_ready", 64'(rdy64), 64'd1);
        out_rdy = 1'b1;
        step();
        check("flush_no_ghost", 64'(vld32), 64'd0);

        for (int i = 0; i < 1500; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            flush   = ($urandom_range(0, 29) == 0);
            in_vld  = ($urandom_range(0, 9) < 7);
            out_rdy = ($urandom_range(0, 9) < 6);
            inst    = $urandom();
            inst[6:0] = ops[$urandom_range(0, 11)];
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
